// File: rtl/button_step_pulser.sv
// Turns two raw push-buttons into one-cycle up/down step pulses for the time counters.
// Auto-repeat while a button is held is built only when BTN_AUTO_REPEAT_EN is defined.
//
// state  | meaning
// IDLE   | no debounced button pressed
// HOLD   | one button pressed, first step issued, waiting for the hold delay
// REPEAT | one button still pressed, issuing a step every repeat period
// CLEAR  | both pressed, clear pulse issued, waiting for full release
module button_step_pulser #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int CNT_W           = 25
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_up,
   input  logic i_btn_down,
   output logic o_up,
   output logic o_down,
   output logic o_repeating
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_CLEAR  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // bit 0 carries the up button, bit 1 the down button
   logic [1:0]       btn_raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [CNT_W-1:0] deb_cnt [2];

   assign btn_raw = {i_btn_down, i_btn_up};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         deb <= '0;
         for (int b = 0; b < 2; b++) begin
            deb_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == deb[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == DEB_LAST) begin
               deb[b]     <= sync2[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   state_t state;
   state_t state_nxt;
   logic   dir_up;
   logic   dir_up_nxt;
   logic   up_nxt;
   logic   dn_nxt;
   logic   press_up;
   logic   press_dn;

   assign press_up = deb[0];
   assign press_dn = deb[1];

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] tmr;
   logic [CNT_W-1:0] tmr_nxt;
   logic [CNT_W-1:0] tmr_last;

   assign tmr_last = (state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

   always_comb begin
      state_nxt  = state;
      dir_up_nxt = dir_up;
      up_nxt     = 1'b0;
      dn_nxt     = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      tmr_nxt    = tmr;
`endif
      case (state)
         ST_IDLE: begin
            if (press_up && press_dn) begin
               up_nxt    = 1'b1;
               dn_nxt    = 1'b1;
               state_nxt = ST_CLEAR;
            end else if (press_up || press_dn) begin
               up_nxt     = press_up;
               dn_nxt     = press_dn;
               dir_up_nxt = press_up;
               state_nxt  = ST_HOLD;
`ifdef BTN_AUTO_REPEAT_EN
               tmr_nxt    = '0;
`endif
            end
         end
         ST_HOLD, ST_REPEAT: begin
            if (!press_up && !press_dn) begin
               state_nxt = ST_IDLE;
            end else if (press_up && press_dn) begin
               up_nxt    = 1'b1;
               dn_nxt    = 1'b1;
               state_nxt = ST_CLEAR;
            end else if (press_up != dir_up) begin
               // swapped buttons within one cycle: restart as a fresh press
               up_nxt     = press_up;
               dn_nxt     = press_dn;
               dir_up_nxt = press_up;
               state_nxt  = ST_HOLD;
`ifdef BTN_AUTO_REPEAT_EN
               tmr_nxt    = '0;
`endif
            end else begin
`ifdef BTN_AUTO_REPEAT_EN
               if (tmr == tmr_last) begin
                  up_nxt    = dir_up;
                  dn_nxt    = !dir_up;
                  state_nxt = ST_REPEAT;
                  tmr_nxt   = '0;
               end else begin
                  tmr_nxt = tmr + CNT_W'(1);
               end
`endif
            end
         end
         ST_CLEAR: begin
            if (!press_up && !press_dn) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_IDLE;
         dir_up <= 1'b0;
         o_up   <= 1'b0;
         o_down <= 1'b0;
      end else begin
         state  <= state_nxt;
         dir_up <= dir_up_nxt;
         o_up   <= up_nxt;
         o_down <= dn_nxt;
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tmr <= '0;
      end else begin
         tmr <= tmr_nxt;
      end
   end

   assign o_repeating = (state == ST_REPEAT);
`else
   assign o_repeating = 1'b0;
`endif

endmodule

// File: tb/tb_button_step_pulser.sv
// Self-checking bench for button_step_pulser: timestamp-based reference model plus directed scenarios.
// Follows BTN_AUTO_REPEAT_EN the same way the design does.
module tb_button_step_pulser;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 3;
   localparam int CW   = 8;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_HELD = 1;
   localparam int M_RPT  = 2;
   localparam int M_CLR  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic o_up;
   logic o_down;
   logic o_repeating;

   button_step_pulser #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .CNT_W          (CW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_btn_up   (btn_up),
      .i_btn_down (btn_down),
      .o_up       (o_up),
      .o_down     (o_down),
      .o_repeating(o_repeating)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   // reference model state; steps are timed from timestamps, not counters
   bit       m_deb [2];
   bit       m_d1 [2];
   bit       m_d2 [2];
   bit       m_hist [2][8];
   int       m_since [2];
   bit [1:0] m_raw;
   int       m_mode = M_IDLE;
   bit       m_dir;
   int       m_last;
   bit       e_up, e_dn;
   bit       pu, pd, flip;

   int up_q[$];
   int dn_q[$];
   int clr_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      up_q.delete();
      dn_q.delete();
      clr_q.delete();
   endtask

   function automatic int first_up_after(input int t);
      foreach (up_q[i]) if (up_q[i] > t) return up_q[i];
      return -1;
   endfunction

   function automatic int dn_count_after(input int t);
      int c = 0;
      foreach (dn_q[i]) if (dn_q[i] > t) c++;
      return c;
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         m_mode = M_IDLE;
         e_up = 1'b0;
         e_dn = 1'b0;
         m_dir = 1'b0;
         m_last = 0;
         for (int b = 0; b < 2; b++) begin
            m_deb[b] = 1'b0;
            m_d1[b] = 1'b0;
            m_d2[b] = 1'b0;
            m_since[b] = 0;
            for (int i = 0; i < 8; i++) m_hist[b][i] = 1'b0;
         end
      end else begin
         pu = m_deb[0];
         pd = m_deb[1];
         e_up = 1'b0;
         e_dn = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (pu && pd) begin
                  e_up = 1'b1; e_dn = 1'b1; m_mode = M_CLR;
               end else if (pu || pd) begin
                  e_up = pu; e_dn = pd; m_dir = pu; m_mode = M_HELD; m_last = edge_n;
               end
            end
            M_HELD, M_RPT: begin
               if (!pu && !pd) begin
                  m_mode = M_IDLE;
               end else if (pu && pd) begin
                  e_up = 1'b1; e_dn = 1'b1; m_mode = M_CLR;
               end else if (pu != m_dir) begin
                  e_up = pu; e_dn = pd; m_dir = pu; m_mode = M_HELD; m_last = edge_n;
               end else if (AUTO && (edge_n - m_last) == ((m_mode == M_HELD) ? HOLD : REP)) begin
                  e_up = m_dir; e_dn = !m_dir; m_mode = M_RPT; m_last = edge_n;
               end
            end
            default: begin
               if (!pu && !pd) m_mode = M_IDLE;
            end
         endcase
         m_raw = {btn_down, btn_up};
         // a level is accepted once the last DEB synchronised samples since the last change all disagree with it
         for (int b = 0; b < 2; b++) begin
            for (int i = 7; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
            m_hist[b][0] = m_d2[b];
            m_since[b]++;
            flip = (m_since[b] >= DEB);
            for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_deb[b]) flip = 1'b0;
            if (flip) begin
               m_deb[b] = !m_deb[b];
               m_since[b] = 0;
            end
            m_d2[b] = m_d1[b];
            m_d1[b] = m_raw[b];
         end
      end
   end

   always @(negedge clk) begin
      if (edge_n > 0) begin
         check("o_up", int'(o_up), int'(e_up));
         check("o_down", int'(o_down), int'(e_dn));
         check("o_repeating", int'(o_repeating), (m_mode == M_RPT) ? 1 : 0);
         if (o_up && o_down) clr_q.push_back(edge_n);
         else if (o_up) up_q.push_back(edge_n);
         else if (o_down) dn_q.push_back(edge_n);
      end
   end

   int k;
   int r_edge;
   int len;

   initial begin
      cyc(3);
      check("reset_up", int'(o_up), 0);
      check("reset_down", int'(o_down), 0);
      check("reset_repeating", int'(o_repeating), 0);
      rst = 1'b0;
      cyc(5);

      // clean up press held 40 cycles
      clear_q();
      k = edge_n + 1;
      btn_up = 1'b1;
      cyc(40);
      btn_up = 1'b0;
      cyc(20);
      check("s1_up_count", up_q.size(), AUTO ? 11 : 1);
      check("s1_first_ofs", (up_q.size() > 0) ? up_q[0] - k : -1, DEB + 2);
      check("s1_second_ofs", (up_q.size() > 1) ? up_q[1] - k : -1, AUTO ? DEB + 2 + HOLD : -1);
      check("s1_other_pulses", dn_q.size() + clr_q.size(), 0);

      // glitches of 3 then 4 cycles
      clear_q();
      btn_up = 1'b1;
      cyc(3);
      btn_up = 1'b0;
      cyc(15);
      check("s2_glitch3", up_q.size(), 0);
      btn_up = 1'b1;
      cyc(4);
      btn_up = 1'b0;
      cyc(15);
      check("s2_glitch4", up_q.size(), 1);

      // both buttons together, released one at a time
      clear_q();
      k = edge_n + 1;
      btn_up = 1'b1;
      btn_down = 1'b1;
      cyc(20);
      btn_up = 1'b0;
      cyc(20);
      btn_down = 1'b0;
      cyc(20);
      check("s3_clear_count", clr_q.size(), 1);
      check("s3_clear_ofs", (clr_q.size() > 0) ? clr_q[0] - k : -1, DEB + 2);
      check("s3_single_steps", up_q.size() + dn_q.size(), 0);

      // down held, then up joins
      clear_q();
      k = edge_n + 1;
      btn_down = 1'b1;
      cyc(25);
      btn_up = 1'b1;
      cyc(20);
      btn_up = 1'b0;
      cyc(10);
      btn_down = 1'b0;
      cyc(15);
      check("s4_down_count", dn_q.size(), AUTO ? 6 : 1);
      check("s4_clear_count", clr_q.size(), 1);
      check("s4_clear_ofs", (clr_q.size() > 0) ? clr_q[0] - k : -1, 31);
      check("s4_steps_after_clear", dn_count_after(k + 31) + up_q.size(), 0);

      // reset while up is held
      clear_q();
      btn_up = 1'b1;
      cyc(30);
      check("s5_pre_reset_rep", int'(o_repeating), AUTO ? 1 : 0);
      rst = 1'b1;
      cyc(1);
      r_edge = edge_n;
      check("s5_rst_up", int'(o_up), 0);
      check("s5_rst_rep", int'(o_repeating), 0);
      rst = 1'b0;
      cyc(15);
      btn_up = 1'b0;
      cyc(15);
      // two synchroniser edges, DEB debounce edges, one output register edge
      check("s5_step_after_rst", first_up_after(r_edge) - r_edge, DEB + 3);

      // random presses, glitches, swaps and occasional resets
      for (int seg = 0; seg < 150; seg++) begin
         btn_up = 1'($urandom_range(0, 1));
         btn_down = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 30);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
         end
         cyc(len);
      end
      btn_up = 1'b0;
      btn_down = 1'b0;
      cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
